// File: rtl/predictor_func_pkg.sv
// Shared fixed-point types, FSM encoding and the truncating Q32.32 multiply
// used by the predictor matrix-vector scheduler.
package predictor_func_pkg;

  localparam int FX_DW   = 64;
  localparam int FX_FRAC = 32;

  typedef logic signed [FX_DW-1:0] fx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } mv_state_t;

  // Full-precision product, then an arithmetic shift: truncation toward -inf.
  function automatic fx_t fx_mul_trunc(input fx_t a, input fx_t b);
    logic signed [2*FX_DW-1:0] full;
    full = (2*FX_DW)'(a) * (2*FX_DW)'(b);
    return fx_t'(full >>> FX_FRAC);
  endfunction

endpackage

// File: rtl/predictor_func_mvmult_mac.sv
// Shared multiply-accumulate: loads the first product of a row, accumulates
// the rest with wrap-around addition.
module predictor_func_mvmult_mac
  import predictor_func_pkg::*;
#(
  parameter int DW = FX_DW
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] prod;
  logic [DW-1:0] acc_reg;

  generate
    if (DW == FX_DW) begin : g_fx
      assign prod = fx_mul_trunc(fx_t'(a), fx_t'(b));
    end else begin : g_generic
      logic signed [2*DW-1:0] full;
      assign full = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
      assign prod = DW'(full >>> FX_FRAC);
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= clear ? prod : acc_reg + prod;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/predictor_func_mvmult_sched.sv
// Matrix-vector product scheduler: walks A row-major through a 1-cycle ROM,
// feeds the shared MAC and writes one y entry per row (ap_ctrl_hs).
module predictor_func_mvmult_sched
  import predictor_func_pkg::*;
#(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  parameter int DW     = 64,
  parameter int A_AW   = 2,
  parameter int Y_AW   = 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [N_COLS*DW-1:0] x_in,
  output logic [A_AW-1:0]      a_address,
  output logic                 a_ce,
  input  logic [DW-1:0]        a_q,
  output logic [Y_AW-1:0]      y_address,
  output logic                 y_ce,
  output logic                 y_we,
  output logic [DW-1:0]        y_d
);

  localparam int IW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int JW = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  mv_state_t       state_reg, state_next;
  logic [IW-1:0]   i_reg;
  logic [JW-1:0]   j_reg, j_d1_reg;
  logic [A_AW-1:0] addr_reg;
  logic            valid_d1_reg, first_d1_reg;
  logic [DW-1:0]   x_reg [N_COLS];
  logic [DW-1:0]   acc;
  logic            accept, last_col, last_row;

  assign accept   = (state_reg == ST_IDLE) && ap_start;
  assign last_col = (j_reg == JW'(N_COLS - 1));
  assign last_row = (i_reg == IW'(N_ROWS - 1));

  generate
    for (genvar gi = 0; gi < N_COLS; gi++) begin : g_x
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          x_reg[gi] <= '0;
        end else if (accept) begin
          x_reg[gi] <= x_in[gi*DW +: DW];
        end
      end
    end
  endgenerate

  // Issue order is strictly row-major, so the ROM address is just a running count.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg    <= ST_IDLE;
      i_reg        <= '0;
      j_reg        <= '0;
      j_d1_reg     <= '0;
      addr_reg     <= '0;
      valid_d1_reg <= 1'b0;
      first_d1_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      valid_d1_reg <= (state_reg == ST_ISSUE);
      first_d1_reg <= (j_reg == '0);
      j_d1_reg     <= j_reg;
      case (state_reg)
        ST_IDLE: if (ap_start) begin
          i_reg    <= '0;
          j_reg    <= '0;
          addr_reg <= '0;
        end
        ST_ISSUE: begin
          j_reg    <= last_col ? '0 : j_reg + 1'b1;
          addr_reg <= addr_reg + 1'b1;
        end
        ST_WRITE: if (!last_row) i_reg <= i_reg + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    ap_done    = 1'b0;
    ap_idle    = 1'b0;
    a_ce       = 1'b0;
    a_address  = '0;
    y_we       = 1'b0;
    y_address  = '0;
    y_d        = '0;
    case (state_reg)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        a_ce      = 1'b1;
        a_address = addr_reg;
        if (last_col) state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_WRITE;
      ST_WRITE: begin
        y_we       = 1'b1;
        y_address  = Y_AW'(i_reg);
        y_d        = acc;
        state_next = last_row ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        ap_done    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ap_ready = ap_done;
  assign y_ce     = y_we;

  predictor_func_mvmult_mac #(.DW(DW)) u_mac (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .clear  (first_d1_reg),
    .en     (valid_d1_reg),
    .a      (a_q),
    .b      (x_reg[j_d1_reg]),
    .acc    (acc)
  );

endmodule

// File: tb/tb_predictor_func_mvmult_sched.sv
// Directed bench: default 2x2 instance plus a 3x4 instance, each with a
// 1-cycle-latency coefficient ROM model.
module tb_predictor_func_mvmult_sched;

  localparam logic [63:0] ONE   = 64'h0000_0001_0000_0000;
  localparam logic [63:0] TWO   = 64'h0000_0002_0000_0000;
  localparam logic [63:0] HALF  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] QTR   = 64'h0000_0000_4000_0000;
  localparam logic [63:0] MHALF = 64'hFFFF_FFFF_8000_0000;

  int errors = 0;
  int checks = 0;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // default 2x2 instance
  logic         start_a = 1'b0;
  logic         done_a, idle_a, ready_a, a_ce_a, y_ce_a, y_we_a;
  logic [127:0] x_a = '0;
  logic [1:0]   a_addr_a;
  logic [63:0]  a_q_a = '0, y_d_a;
  logic [0:0]   y_addr_a;
  logic [63:0]  rom_a [4];

  predictor_func_mvmult_sched dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(start_a), .ap_done(done_a),
    .ap_idle(idle_a), .ap_ready(ready_a), .x_in(x_a), .a_address(a_addr_a),
    .a_ce(a_ce_a), .a_q(a_q_a), .y_address(y_addr_a), .y_ce(y_ce_a),
    .y_we(y_we_a), .y_d(y_d_a)
  );

  always @(posedge ap_clk) if (a_ce_a) a_q_a <= rom_a[a_addr_a];

  // 3x4 instance
  logic         start_b = 1'b0;
  logic         done_b, idle_b, ready_b, a_ce_b, y_ce_b, y_we_b;
  logic [255:0] x_b = '0;
  logic [3:0]   a_addr_b;
  logic [63:0]  a_q_b = '0, y_d_b;
  logic [1:0]   y_addr_b;
  logic [63:0]  rom_b [12];

  predictor_func_mvmult_sched #(.N_ROWS(3), .N_COLS(4), .DW(64), .A_AW(4), .Y_AW(2)) dut3 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(start_b), .ap_done(done_b),
    .ap_idle(idle_b), .ap_ready(ready_b), .x_in(x_b), .a_address(a_addr_b),
    .a_ce(a_ce_b), .a_q(a_q_b), .y_address(y_addr_b), .y_ce(y_ce_b),
    .y_we(y_we_b), .y_d(y_d_b)
  );

  always @(posedge ap_clk) if (a_ce_b) a_q_b <= rom_b[a_addr_b];

  // write / done / address logs
  int          ycnt_a = 0, dcnt_a = 0, ycnt_b = 0, acnt_b = 0;
  logic [63:0] ylog_a_val [32];
  int          ylog_a_addr [32], ylog_a_cyc [32], dlog_a [8];
  logic [63:0] ylog_b_val [8];
  int          ylog_b_addr [8], ylog_b_cyc [8], alog_b [16];

  always @(negedge ap_clk) begin
    if (y_we_a) begin
      ylog_a_val[ycnt_a % 32]  = y_d_a;
      ylog_a_addr[ycnt_a % 32] = int'(y_addr_a);
      ylog_a_cyc[ycnt_a % 32]  = cyc;
      ycnt_a++;
    end
    if (done_a) begin
      dlog_a[dcnt_a % 8] = cyc;
      dcnt_a++;
    end
    if (y_we_b) begin
      ylog_b_val[ycnt_b % 8]  = y_d_b;
      ylog_b_addr[ycnt_b % 8] = int'(y_addr_b);
      ylog_b_cyc[ycnt_b % 8]  = cyc;
      ycnt_b++;
    end
    if (a_ce_b) begin
      alog_b[acnt_b % 16] = int'(a_addr_b);
      acnt_b++;
    end
  end

  // One run on the 2x2 instance; reports start cycle, done cycle and timeout.
  task automatic run_a(input logic [63:0] x0, input logic [63:0] x1,
                       output int c0, output int d_at, output bit to, output logic rdy);
    @(negedge ap_clk);
    x_a = {x1, x0};
    start_a = 1'b1;
    c0 = cyc;
    @(negedge ap_clk);
    start_a = 1'b0;
    to = 1'b1;
    d_at = 0;
    rdy = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done_a) begin
        d_at = cyc;
        rdy = ready_a;
        to = 1'b0;
        break;
      end
      @(negedge ap_clk);
    end
    #1;
  endtask

  task automatic test_reset;
    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    checks++; if (idle_a !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle_a); end
    checks++; if ({done_a, ready_a, a_ce_a, y_we_a, y_ce_a} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {done_a, ready_a, a_ce_a, y_we_a, y_ce_a}); end
    checks++; if ({a_addr_a, y_addr_a, y_d_a} !== 67'b0) begin errors++; $display("FAIL reset_data: got %h want 0", {a_addr_a, y_addr_a, y_d_a}); end
    checks++; if ({idle_b, done_b, a_ce_b, y_we_b} !== 4'b1000) begin errors++; $display("FAIL reset_dut3: got %b want 1000", {idle_b, done_b, a_ce_b, y_we_b}); end
    ap_rst = 1'b0;
    @(negedge ap_clk);
  endtask

  task automatic test_identity;
    int c0, d_at, base;
    bit to;
    logic rdy;
    rom_a = '{ONE, 64'h0, 64'h0, ONE};
    base = ycnt_a;
    run_a(64'h0000_0003_0000_0000, 64'hFFFF_FFFE_0000_0000, c0, d_at, to, rdy);
    checks++; if (to) begin errors++; $display("FAIL ident_timeout: got no ap_done want ap_done"); end
    checks++; if (d_at - c0 !== 9) begin errors++; $display("FAIL ident_latency: got %0d want 9", d_at - c0); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ident_ready: got %b want 1", rdy); end
    checks++; if (ycnt_a - base !== 2) begin errors++; $display("FAIL ident_writes: got %0d want 2", ycnt_a - base); end
    checks++; if (ylog_a_val[base % 32] !== 64'h0000_0003_0000_0000) begin errors++; $display("FAIL ident_y0: got %h want 0000000300000000", ylog_a_val[base % 32]); end
    checks++; if (ylog_a_val[(base + 1) % 32] !== 64'hFFFF_FFFE_0000_0000) begin errors++; $display("FAIL ident_y1: got %h want fffffffe00000000", ylog_a_val[(base + 1) % 32]); end
    checks++; if (ylog_a_addr[base % 32] !== 0 || ylog_a_addr[(base + 1) % 32] !== 1) begin errors++; $display("FAIL ident_yaddr: got %0d,%0d want 0,1", ylog_a_addr[base % 32], ylog_a_addr[(base + 1) % 32]); end
    checks++; if (ylog_a_cyc[base % 32] - c0 !== 4 || ylog_a_cyc[(base + 1) % 32] - c0 !== 8) begin errors++; $display("FAIL ident_ycyc: got %0d,%0d want 4,8", ylog_a_cyc[base % 32] - c0, ylog_a_cyc[(base + 1) % 32] - c0); end
    $display("identity: c0=%0d done=+%0d y0=%h y1=%h", c0, d_at - c0, ylog_a_val[base % 32], ylog_a_val[(base + 1) % 32]);
  endtask

  task automatic test_fractional;
    int c0, d_at, base;
    bit to;
    logic rdy;
    rom_a = '{MHALF, QTR, TWO, ONE};
    base = ycnt_a;
    run_a(64'h0000_0004_0000_0000, 64'h0000_0008_0000_0000, c0, d_at, to, rdy);
    checks++; if (ycnt_a - base !== 2 || to) begin errors++; $display("FAIL frac_writes: got %0d timeout=%b want 2 timeout=0", ycnt_a - base, to); end
    checks++; if (ylog_a_val[base % 32] !== 64'h0) begin errors++; $display("FAIL frac_y0: got %h want 0", ylog_a_val[base % 32]); end
    checks++; if (ylog_a_val[(base + 1) % 32] !== 64'h0000_0010_0000_0000) begin errors++; $display("FAIL frac_y1: got %h want 0000001000000000", ylog_a_val[(base + 1) % 32]); end
    $display("fractional: y0=%h y1=%h", ylog_a_val[base % 32], ylog_a_val[(base + 1) % 32]);
    // 1 LSB * 0.5 truncates to 0; -1 LSB * 0.5 truncates toward -inf to -1 LSB
    rom_a = '{64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    base = ycnt_a;
    run_a(HALF, 64'h0, c0, d_at, to, rdy);
    checks++; if (ylog_a_val[base % 32] !== 64'h0 || to) begin errors++; $display("FAIL trunc_pos: got %h want 0", ylog_a_val[base % 32]); end
    checks++; if (ylog_a_val[(base + 1) % 32] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL trunc_neg: got %h want ffffffffffffffff", ylog_a_val[(base + 1) % 32]); end
    $display("truncation: y0=%h y1=%h", ylog_a_val[base % 32], ylog_a_val[(base + 1) % 32]);
  endtask

  task automatic test_wrap;
    int c0, d_at, base;
    bit to;
    logic rdy;
    rom_a = '{ONE, ONE, 64'h0, 64'h0};
    base = ycnt_a;
    run_a(64'h7FFF_FFFF_0000_0000, ONE, c0, d_at, to, rdy);
    checks++; if (ylog_a_val[base % 32] !== 64'h8000_0000_0000_0000 || to) begin errors++; $display("FAIL wrap_y0: got %h want 8000000000000000", ylog_a_val[base % 32]); end
    checks++; if (ylog_a_val[(base + 1) % 32] !== 64'h0) begin errors++; $display("FAIL wrap_y1: got %h want 0", ylog_a_val[(base + 1) % 32]); end
    $display("wrap: y0=%h", ylog_a_val[base % 32]);
  endtask

  task automatic test_back_to_back;
    int base_y, base_d;
    bit to1, to2;
    rom_a = '{ONE, 64'h0, 64'h0, ONE};
    base_y = ycnt_a;
    base_d = dcnt_a;
    @(negedge ap_clk);
    x_a = {TWO, ONE};
    start_a = 1'b1;
    to1 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge ap_clk);
      if (done_a) begin to1 = 1'b0; break; end
    end
    x_a = {64'h0000_0006_0000_0000, 64'h0000_0005_0000_0000};
    to2 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge ap_clk);
      if (done_a) begin to2 = 1'b0; break; end
    end
    start_a = 1'b0;
    repeat (6) @(negedge ap_clk);
    #1;
    checks++; if (to1 || to2) begin errors++; $display("FAIL b2b_timeout: got timeouts %b%b want 00", to1, to2); end
    checks++; if (dcnt_a - base_d !== 2) begin errors++; $display("FAIL b2b_dones: got %0d want 2", dcnt_a - base_d); end
    checks++; if (dlog_a[(base_d + 1) % 8] - dlog_a[base_d % 8] !== 10) begin errors++; $display("FAIL b2b_period: got %0d want 10", dlog_a[(base_d + 1) % 8] - dlog_a[base_d % 8]); end
    checks++; if (ycnt_a - base_y !== 4) begin errors++; $display("FAIL b2b_writes: got %0d want 4", ycnt_a - base_y); end
    checks++; if (ylog_a_val[base_y % 32] !== ONE || ylog_a_val[(base_y + 1) % 32] !== TWO) begin errors++; $display("FAIL b2b_run1: got %h,%h want %h,%h", ylog_a_val[base_y % 32], ylog_a_val[(base_y + 1) % 32], ONE, TWO); end
    checks++; if (ylog_a_val[(base_y + 2) % 32] !== 64'h0000_0005_0000_0000 || ylog_a_val[(base_y + 3) % 32] !== 64'h0000_0006_0000_0000) begin errors++; $display("FAIL b2b_run2: got %h,%h want 0000000500000000,0000000600000000", ylog_a_val[(base_y + 2) % 32], ylog_a_val[(base_y + 3) % 32]); end
    $display("back_to_back: dones=%0d period=%0d writes=%0d", dcnt_a - base_d, dlog_a[(base_d + 1) % 8] - dlog_a[base_d % 8], ycnt_a - base_y);
  endtask

  task automatic test_reset_midop;
    int c0, d_at, base_y, base_d;
    bit to;
    logic rdy;
    rom_a = '{ONE, 64'h0, 64'h0, ONE};
    base_y = ycnt_a;
    base_d = dcnt_a;
    @(negedge ap_clk);
    x_a = {TWO, ONE};
    start_a = 1'b1;
    @(negedge ap_clk);
    start_a = 1'b0;
    repeat (4) @(negedge ap_clk);
    checks++; if (a_ce_a !== 1'b1 || a_addr_a !== 2'd2) begin errors++; $display("FAIL midop_row1_issue: got ce=%b addr=%0d want ce=1 addr=2", a_ce_a, a_addr_a); end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    checks++; if (idle_a !== 1'b1 || y_we_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL midop_abort: got idle=%b we=%b done=%b want 1,0,0", idle_a, y_we_a, done_a); end
    ap_rst = 1'b0;
    repeat (15) @(negedge ap_clk);
    #1;
    checks++; if (ycnt_a - base_y !== 1 || dcnt_a !== base_d) begin errors++; $display("FAIL midop_nowrite: got writes=%0d dones=%0d want 1,0", ycnt_a - base_y, dcnt_a - base_d); end
    base_y = ycnt_a;
    run_a(64'h0000_0007_0000_0000, ONE, c0, d_at, to, rdy);
    checks++; if (to || ylog_a_val[base_y % 32] !== 64'h0000_0007_0000_0000 || ylog_a_val[(base_y + 1) % 32] !== ONE) begin errors++; $display("FAIL midop_fresh: got %h,%h want 0000000700000000,%h", ylog_a_val[base_y % 32], ylog_a_val[(base_y + 1) % 32], ONE); end
    $display("reset_midop: fresh y0=%h y1=%h", ylog_a_val[base_y % 32], ylog_a_val[(base_y + 1) % 32]);
  endtask

  task automatic test_param_sweep;
    logic [63:0]        xv [4];
    logic [63:0]        expv [3];
    logic [63:0]        acc;
    logic signed [127:0] pa, pb, p;
    int                 c0, d_at, base_y, base_a;
    bit                 to;
    for (int k = 0; k < 12; k++) rom_b[k] = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) xv[k] = {$urandom, $urandom};
    for (int r = 0; r < 3; r++) begin
      acc = '0;
      for (int c = 0; c < 4; c++) begin
        pa = {{64{rom_b[r*4+c][63]}}, rom_b[r*4+c]};
        pb = {{64{xv[c][63]}}, xv[c]};
        p = pa * pb;
        acc = acc + p[95:32];
      end
      expv[r] = acc;
    end
    base_y = ycnt_b;
    base_a = acnt_b;
    @(negedge ap_clk);
    x_b = {xv[3], xv[2], xv[1], xv[0]};
    start_b = 1'b1;
    c0 = cyc;
    @(negedge ap_clk);
    start_b = 1'b0;
    to = 1'b1;
    d_at = 0;
    for (int k = 0; k < 80; k++) begin
      if (done_b) begin d_at = cyc; to = 1'b0; break; end
      @(negedge ap_clk);
    end
    #1;
    checks++; if (to || d_at - c0 !== 19) begin errors++; $display("FAIL sweep_latency: got %0d timeout=%b want 19", d_at - c0, to); end
    checks++; if (ycnt_b - base_y !== 3 || acnt_b - base_a !== 12) begin errors++; $display("FAIL sweep_counts: got writes=%0d reads=%0d want 3,12", ycnt_b - base_y, acnt_b - base_a); end
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (ylog_b_val[(base_y + r) % 8] !== expv[r] || ylog_b_addr[(base_y + r) % 8] !== r || ylog_b_cyc[(base_y + r) % 8] - c0 !== 6 * (r + 1)) begin
        errors++;
        $display("FAIL sweep_y%0d: got %h addr=%0d cyc=+%0d want %h addr=%0d cyc=+%0d", r, ylog_b_val[(base_y + r) % 8], ylog_b_addr[(base_y + r) % 8], ylog_b_cyc[(base_y + r) % 8] - c0, expv[r], r, 6 * (r + 1));
      end
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (alog_b[(base_a + k) % 16] !== k) begin errors++; $display("FAIL sweep_addr%0d: got %0d want %0d", k, alog_b[(base_a + k) % 16], k); end
    end
    $display("param_sweep: done=+%0d y=%h,%h,%h", d_at - c0, ylog_b_val[base_y % 8], ylog_b_val[(base_y + 1) % 8], ylog_b_val[(base_y + 2) % 8]);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_fractional();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
